// File: rtl/div_ctrl.sv
// Iterative restoring divider for the EX stage: one quotient bit per cycle,
// signed/unsigned, divide-by-zero short cut, flush (annul) and stall handshake.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVZERO,
    ST_ON,
    ST_END
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvsr;
  logic               neg_quo;
  logic               neg_rem;
  logic [WIDTH:0]     partial;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;

  // quo starts as the dividend magnitude and is shifted out MSB-first while
  // the quotient bits are shifted in at the bottom.
  assign partial = {rem, quo[WIDTH-1]};
  assign diff    = partial - {1'b0, dvsr};
  assign quo_fix = neg_quo ? -quo : quo;
  assign rem_fix = neg_rem ? -rem : rem;
  assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  assign ready_o    = (state == ST_END);
  assign stallreq_o = rst & start_i & (state != ST_END) & ~annul_i;

  always_comb begin
    state_n = state;
    if (annul_i) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start_i) state_n = (opdata2_i == '0) ? ST_DIVZERO : ST_ON;
        ST_DIVZERO: state_n = ST_END;
        ST_ON:      if (cnt == CNT_W'(WIDTH)) state_n = ST_END;
        ST_END:     if (!start_i) state_n = ST_IDLE;
        default:    state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && state_n == ST_ON) begin
        quo     <= op1_abs;
        dvsr    <= op2_abs;
        rem     <= '0;
        cnt     <= '0;
        neg_quo <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
        neg_rem <= signed_div_i & opdata1_i[WIDTH-1];
      end else if (state == ST_ON && state_n == ST_ON) begin
        cnt <= cnt + CNT_W'(1);
        if (!diff[WIDTH]) begin
          rem <= diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= partial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
      end
      // Result is loaded once on entry to END and otherwise forced to zero.
      if (state_n != ST_END) begin
        result_o <= '0;
      end else if (state != ST_END) begin
        result_o <= (state == ST_DIVZERO) ? '0 : {rem_fix, quo_fix};
      end
    end
  end

endmodule
